// File: rtl/robo_pkg.sv
// robo_pkg: shared command, state and direction encodings for the robot motor stage
package robo_pkg;
    localparam logic [1:0] CMD_PARADO = 2'b00;
    localparam logic [1:0] CMD_FRENTE = 2'b10;
    localparam logic [1:0] CMD_GIRO   = 2'b01;
    localparam logic DIR_FRENTE = 1'b1;
    localparam logic DIR_RE     = 1'b0;
    typedef enum logic [1:0] {PARADO, ACELERANDO, CRUZEIRO, PAUSA} estado_t;
    // the illegal 11 command means stop
    function automatic logic [1:0] decodifica(input logic [1:0] c);
        return (c == 2'b11) ? CMD_PARADO : c;
    endfunction
endpackage

// File: rtl/gerador_pwm.sv
// gerador_pwm: free-running PWM counter with clear, wrap flag and duty compare
module gerador_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                wrap,
    output logic                pwm
);
    localparam logic [PWM_BITS-1:0] UM = 1;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    // clear restarts the period so a new command begins with a full high phase
    always_comb cnt_d = clr ? '0 : cnt_q + UM;
    // counter register
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign wrap = &cnt_q;
    assign pwm  = en && (cnt_q < duty);
endmodule

// File: rtl/driver_motores.sv
// driver_motores: differential-drive motor stage with soft-start ramp and dead-time coast
module driver_motores
    import robo_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_STEP   = 4,
    parameter int DUTY_MAX    = 200,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                avancar,
    input  logic                girar,
    output logic                pwm_esq,
    output logic                pwm_dir,
    output logic                dir_esq,
    output logic                dir_dir,
    output logic [PWM_BITS-1:0] duty,
    output logic                ocupado
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   MAX_X     = (PWM_BITS+1)'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] DUTY_TOPO = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] DUTY_INI  = (RAMP_STEP >= DUTY_MAX) ? DUTY_TOPO : PWM_BITS'(RAMP_STEP);
    localparam logic [DW-1:0]       DEAD_INI  = DW'(DEAD_CYCLES - 1);
    localparam logic [DW-1:0]       DEAD_UM   = 1;

    estado_t             estado_q, estado_d;
    logic [1:0]          cmd_q, cmd_d, cmd_ativo_q, cmd_ativo_d, cmd_n;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic                dir_esq_q, dir_esq_d, dir_dir_q, dir_dir_d;
    logic [PWM_BITS:0]   soma;
    logic                clr, wrap, pwm, pwm_en, partida;

    // next state: command change coasts first, ramp advances on wrap, start from rest or after coast
    always_comb begin
        cmd_d       = {avancar, girar};
        cmd_n       = decodifica(cmd_q);
        soma        = {1'b0, duty_q} + STEP_X;
        estado_d    = estado_q;
        cmd_ativo_d = cmd_ativo_q;
        duty_d      = duty_q;
        dead_d      = dead_q;
        dir_esq_d   = dir_esq_q;
        dir_dir_d   = dir_dir_q;
        partida     = 1'b0;
        case (estado_q)
            PARADO: partida = (cmd_n != CMD_PARADO);
            ACELERANDO, CRUZEIRO:
                if (cmd_n != cmd_ativo_q) begin
                    estado_d = PAUSA;
                    duty_d   = '0;
                    dead_d   = DEAD_INI;
                end else if (estado_q == ACELERANDO && wrap) begin
                    duty_d   = (soma >= MAX_X) ? DUTY_TOPO : soma[PWM_BITS-1:0];
                    estado_d = (duty_d == DUTY_TOPO) ? CRUZEIRO : ACELERANDO;
                end
            PAUSA:
                if (dead_q != '0) dead_d = dead_q - DEAD_UM;
                else if (cmd_n == CMD_PARADO) estado_d = PARADO;
                else partida = 1'b1;
            default: estado_d = PARADO;
        endcase
        if (partida) begin
            estado_d    = ACELERANDO;
            cmd_ativo_d = cmd_n;
            duty_d      = DUTY_INI;
            dir_esq_d   = DIR_FRENTE;
            dir_dir_d   = (cmd_n == CMD_GIRO) ? DIR_RE : DIR_FRENTE;
        end
        clr = partida;
    end

    // state, command and direction registers
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            estado_q    <= PARADO;
            cmd_q       <= CMD_PARADO;
            cmd_ativo_q <= CMD_PARADO;
            duty_q      <= '0;
            dead_q      <= '0;
            dir_esq_q   <= DIR_FRENTE;
            dir_dir_q   <= DIR_FRENTE;
        end else begin
            estado_q    <= estado_d;
            cmd_q       <= cmd_d;
            cmd_ativo_q <= cmd_ativo_d;
            duty_q      <= duty_d;
            dead_q      <= dead_d;
            dir_esq_q   <= dir_esq_d;
            dir_dir_q   <= dir_dir_d;
        end

    assign pwm_en = (estado_q == ACELERANDO) || (estado_q == CRUZEIRO);

    gerador_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clock(clock),
        .reset(reset),
        .clr  (clr),
        .en   (pwm_en),
        .duty (duty_q),
        .wrap (wrap),
        .pwm  (pwm)
    );

    assign pwm_esq = pwm;
    assign pwm_dir = pwm;
    assign dir_esq = dir_esq_q;
    assign dir_dir = dir_dir_q;
    assign duty    = duty_q;
    assign ocupado = (estado_q == ACELERANDO) || (estado_q == PAUSA);
endmodule

// File: tb/tb_driver_motores.sv
// tb_driver_motores: randomized scoreboard bench against a timeline-based reference model
module tb_driver_motores;
    localparam int PERIODO = 256;
    localparam int STEP    = 4;
    localparam int DMAX    = 200;
    localparam int DEAD    = 16;

    logic clock = 1'b0, reset = 1'b1, avancar = 1'b0, girar = 1'b0;
    logic pwm_esq, pwm_dir, dir_esq, dir_dir, ocupado;
    logic [7:0] duty;

    driver_motores dut (
        .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
        .pwm_esq(pwm_esq), .pwm_dir(pwm_dir), .dir_esq(dir_esq), .dir_dir(dir_dir),
        .duty(duty), .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic pe;
        logic pd;
        logic de;
        logic dd;
        logic [7:0] duty;
        logic oc;
    } saida_t;

    saida_t fila[$];
    int testes = 0, falhas = 0;

    // model: 0 stopped, 1 driving (t = cycles since start), 2 coasting (ct = cycles into coast)
    int m_cmdq = 0, m_run = 0, m_act = 0, m_t = 0, m_ct = 0;
    logic m_de = 1'b1, m_dd = 1'b1;

    function automatic int norm(input int c);
        return (c == 3) ? 0 : c;
    endfunction

    function automatic saida_t esperado();
        saida_t e;
        int d;
        d = (m_run == 1) ? (((m_t / PERIODO) + 1) * STEP) : 0;
        if (d > DMAX) d = DMAX;
        e.pe = (m_run == 1) && ((m_t % PERIODO) < d);
        e.pd = e.pe;
        e.de = m_de;
        e.dd = m_dd;
        e.duty = 8'(d);
        e.oc = (m_run == 2) || (m_run == 1 && d < DMAX);
        return e;
    endfunction

    task automatic partir(input int c);
        m_run = 1;
        m_act = c;
        m_t = 0;
        m_de = 1'b1;
        m_dd = (c == 1) ? 1'b0 : 1'b1;
    endtask

    // reference model: advance the timeline on each edge and queue the expected outputs
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cmdq = 0; m_run = 0; m_t = 0; m_ct = 0; m_de = 1'b1; m_dd = 1'b1;
            fila.delete();
        end else begin
            case (m_run)
                0: if (norm(m_cmdq) != 0) partir(norm(m_cmdq));
                1: if (norm(m_cmdq) != m_act) begin m_run = 2; m_ct = 0; end else m_t++;
                default:
                    if (m_ct == DEAD - 1) begin
                        if (norm(m_cmdq) == 0) m_run = 0;
                        else partir(norm(m_cmdq));
                    end else m_ct++;
            endcase
            m_cmdq = {avancar, girar};
        end
        fila.push_back(esperado());
    end

    // monitor: compare each presented output against the queued expectation
    always @(negedge clock) begin
        saida_t e, g;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            g = {pwm_esq, pwm_dir, dir_esq, dir_dir, duty, ocupado};
            testes++;
            if (g !== e) begin
                falhas++;
                $display("FAIL saida t=%0t got pwm=%b%b dir=%b%b duty=%0d oc=%b expected pwm=%b%b dir=%b%b duty=%0d oc=%b",
                         $time, g.pe, g.pd, g.de, g.dd, g.duty, g.oc, e.pe, e.pd, e.de, e.dd, e.duty, e.oc);
            end
        end
    end

    task automatic cmd(input logic a, input logic g, input int n);
        avancar = a;
        girar = g;
        repeat (n) @(negedge clock);
    endtask

    task automatic checar(input string nome, input logic [12:0] got, input logic [12:0] exp);
        testes++;
        if (got !== exp) begin
            falhas++;
            $display("FAIL %s got %h expected %h", nome, got, exp);
        end
    endtask

    initial begin
        int n;
        logic a, g;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checar("reset_inicial", {pwm_esq, pwm_dir, dir_esq, dir_dir, duty, ocupado}, {4'b0011, 8'd0, 1'b0});
        reset = 1'b0;
        cmd(1, 0, 49 * PERIODO + 40);
        checar("cruzeiro", {pwm_esq, pwm_dir, dir_esq, dir_dir, duty, ocupado}, {pwm_esq, pwm_dir, 2'b11, 8'd200, 1'b0});
        cmd(0, 1, 300);
        cmd(0, 0, 40);
        cmd(1, 1, 50);
        checar("ilegal_parado", {pwm_esq, pwm_dir, duty, ocupado, 2'b00}, 13'd0);
        cmd(1, 0, 20);
        for (int i = 0; i < 21; i++) cmd(i % 2 == 0, i % 2 != 0, 1);
        cmd(0, 1, 60);
        cmd(0, 0, 40);
        cmd(1, 0, 24 * PERIODO + 10);
        checar("duty_meio", {5'd0, duty}, {5'd0, 8'd100});
        #2 reset = 1'b1;
        #1 checar("reset_assinc", {pwm_esq, pwm_dir, dir_esq, dir_dir, duty, ocupado}, {4'b0011, 8'd0, 1'b0});
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cmd(1, 0, 3);
        checar("rampa_reinicia", {5'd0, duty}, {5'd0, 8'd4});
        cmd(1, 0, 600);
        cmd(1, 0, 49 * PERIODO);
        cmd(0, 0, 1);
        cmd(1, 0, 300);
        for (int i = 0; i < 150; i++) begin
            a = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 800)) : int'($urandom_range(1, 40));
            cmd(a, g, n);
        end
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end
endmodule
